state_trace_buffer: RTL

//  Downstream of the grouped-async RA datapath. Samples network_state each time iteration_number advances.

---
 rtl/state_trace_buffer_pkg.sv | 22 ++
 rtl/state_trace_buffer_if.sv | 18 +
 rtl/state_trace_buffer_fifo.sv | 57 +++++
 rtl/state_trace_buffer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/state_trace_buffer_pkg.sv
// Shared types for the state trace buffer.
//   STATE_W / LOG_ITER_W : default widths of network_state / iteration_number
//   trace_entry_t        : one buffered sample {state, iter, last}
//   trace_state_t        : capture FSM states
package state_trace_buffer_pkg;

   localparam int STATE_W    = 64;
   localparam int LOG_ITER_W = 16;

   typedef struct packed {
      logic [STATE_W-1:0]    state;
      logic [LOG_ITER_W-1:0] iter;
      logic                  last;
   } trace_entry_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_CAPTURE,
      T_DRAIN
   } trace_state_t;

endpackage

// File: rtl/state_trace_buffer_if.sv
// Host-side drain channel of the trace buffer (valid/ready).
//   valid : entry available        ready : host accepts entry
//   state : entry state            iter  : entry iteration
//   last  : entry is the run's final steady state
// master = trace buffer, slave = host.
interface state_trace_buffer_if #(
   parameter int STATE    = 64,
   parameter int LOG_ITER = 16
);
   logic                valid;
   logic                ready;
   logic [STATE-1:0]    state;
   logic [LOG_ITER-1:0] iter;
   logic                last;

   modport master (output valid, output state, output iter, output last, input ready);
   modport slave  (input valid, input state, input iter, input last, output ready);
endinterface

// File: rtl/state_trace_buffer_fifo.sv
// First-word-fall-through FIFO; a written word is visible at rdata the
// cycle after the push. Push while full is accepted only alongside a pop.
//   clk, rst (async active-low)
//   push, wdata : write side        pop : consume head (ignored when empty)
//   rdata       : head word         level/empty : occupancy status
module state_trace_buffer_fifo #(
   parameter int WIDTH     = 81,
   parameter int DEPTH     = 256,
   parameter int LOG_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 pop,
   output logic [WIDTH-1:0]     rdata,
   output logic [LOG_DEPTH:0]   level,
   output logic                 empty
);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [LOG_DEPTH-1:0] wr_ptr_reg;
   logic [LOG_DEPTH-1:0] rd_ptr_reg;
   logic [LOG_DEPTH:0]   count_reg;
   logic                 full;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count_reg == (LOG_DEPTH+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr_reg];
   assign level   = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wdata;
   end

   // Pointers are exactly LOG_DEPTH wide, so they wrap modulo DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/state_trace_buffer.sv
// Samples network_state whenever iteration_number advances during a run,
// buffers {state, iter, last} entries and drains them to the host.
// The run's final steady state is always stored, tagged last.
//   clk, rst (async active-low), arm (start pulse)
//   network_state, steady_state, iteration_number : datapath inputs
//   host     : valid/ready drain channel (master side)
//   overflow : sticky, a sample was dropped this run
//   busy     : run in progress (capturing or draining)
//   level    : FIFO occupancy
module state_trace_buffer
   import state_trace_buffer_pkg::*;
#(
   parameter int STATE     = STATE_W,
   parameter int LOG_ITER  = LOG_ITER_W,
   parameter int DEPTH     = 256,
   parameter int LOG_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic [STATE-1:0]      network_state,
   input  logic                  steady_state,
   input  logic [LOG_ITER-1:0]   iteration_number,
   state_trace_buffer_if.master  host,
   output logic                  overflow,
   output logic                  busy,
   output logic [LOG_DEPTH:0]    level
);

   localparam int WIDTH = STATE + LOG_ITER + 1;

   trace_state_t          fsm_reg;
   logic [LOG_ITER-1:0]   iter_q_reg;
   logic                  overflow_reg;
   logic                  busy_reg;

   logic                  push;
   logic                  final_write;
   logic                  drop;
   logic                  fifo_empty;
   logic                  pop;
   logic [WIDTH-1:0]      wdata;
   logic [WIDTH-1:0]      rdata;

   // Write request decode. The last FIFO slot is held back for the final
   // entry, so ordinary samples are dropped once level reaches DEPTH-1.
   always_comb begin
      push        = 1'b0;
      final_write = 1'b0;
      drop        = 1'b0;
      case (fsm_reg)
         T_IDLE: begin
            if (arm) begin
               push        = 1'b1;
               final_write = steady_state;
            end
         end
         T_CAPTURE: begin
            if (steady_state) begin
               push        = 1'b1;
               final_write = 1'b1;
            end else if (iteration_number != iter_q_reg) begin
               push = 1'b1;
            end
         end
         default: ;
      endcase
      if (push && !final_write && (level >= (LOG_DEPTH+1)'(DEPTH-1))) begin
         push = 1'b0;
         drop = 1'b1;
      end
   end

   assign wdata = {network_state, iteration_number, final_write};
   assign pop   = host.valid && host.ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_reg      <= T_IDLE;
         iter_q_reg   <= '0;
         overflow_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         case (fsm_reg)
            T_IDLE: begin
               if (arm) begin
                  fsm_reg      <= steady_state ? T_DRAIN : T_CAPTURE;
                  busy_reg     <= 1'b1;
                  iter_q_reg   <= iteration_number;
                  overflow_reg <= drop;
               end
            end
            T_CAPTURE: begin
               if (steady_state) begin
                  fsm_reg    <= T_DRAIN;
                  iter_q_reg <= iteration_number;
               end else if (iteration_number != iter_q_reg) begin
                  iter_q_reg <= iteration_number;
                  if (drop) overflow_reg <= 1'b1;
               end
            end
            T_DRAIN: begin
               // Empty FIFO means out_valid is low, so no handshake is pending.
               if (fifo_empty) begin
                  fsm_reg  <= T_IDLE;
                  busy_reg <= 1'b0;
               end
            end
            default: begin
               fsm_reg  <= T_IDLE;
               busy_reg <= 1'b0;
            end
         endcase
      end
   end

   state_trace_buffer_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .level (level),
      .empty (fifo_empty)
   );

   assign host.valid = !fifo_empty;
   assign {host.state, host.iter, host.last} = rdata;
   assign overflow = overflow_reg;
   assign busy     = busy_reg;

endmodule
